// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline hazard controller. It generates the stall and flush
// controls for a 5-stage pipeline: load-use bubbles, multi-cycle EX holds and
// branch redirects, and it keeps a saturating count of PC-stall cycles.
// Latency: the control outputs are combinational from the inputs, state and mc_cnt.
// Only the FSM state, mc_cnt and stall_cnt are registered.
// Backpressure: the block has no handshake. The stalls hold the upstream stages,
// and the flushes insert bubbles.
//
// Optional feature: define PIPE_MC_UNIT_EN to enable the multi-cycle EX unit
// (ex_mc_start, mc_busy, mc_done). When it is undefined, ex_mc_start is ignored,
// the FSM stays in RUN, and mc_busy and mc_done stay 0.
//
// Ports:
//   clk, rst (async, active-low)
//   id_rs1/id_rs2/id_use_rs1/id_use_rs2 : source operands of the ID instruction
//   ex_wR/ex_is_load/ex_mc_start        : the EX instruction
//   mem_redirect                        : taken branch/jump in MEM
//   pc_stall, ifid_stall/flush, idex_stall/flush, exmem_flush : pipeline controls
//   mc_busy, mc_done                    : multi-cycle unit status
//   stall_cnt                           : saturating count of pc_stall cycles
module pipe_hazard_ctrl #(
  parameter int MC_LAT = 4,   // EX hold cycles for a multi-cycle op, 2..16
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_wR,
  input  logic             ex_is_load,
  input  logic             ex_mc_start,
  input  logic             mem_redirect,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             mc_busy,
  output logic             mc_done,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] mc_cnt, mc_cnt_nxt;
  logic       lu_hazard;
  logic       mc_start_req;

  // x0 is never written, so a load that targets it cannot create a dependency.
  assign lu_hazard = ex_is_load && (ex_wR != 5'd0) &&
                     ((id_use_rs1 && (id_rs1 == ex_wR)) ||
                      (id_use_rs2 && (id_rs2 == ex_wR)));

`ifdef PIPE_MC_UNIT_EN
  assign mc_start_req = ex_mc_start;
`else
  // With no multi-cycle unit, nothing can start a hold. The FSM therefore never
  // leaves RUN, and mc_busy and mc_done stay at 0.
  logic unused_mc_start;
  assign unused_mc_start = ex_mc_start;
  assign mc_start_req    = 1'b0;
`endif

  // Priority: redirect > MC_BUSY > mc start > load-use > normal flow.
  // No branch asserts both a stall and a flush of the same register.
  always_comb begin
    state_nxt   = state;
    mc_cnt_nxt  = mc_cnt;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    mc_busy     = 1'b0;
    mc_done     = 1'b0;

    if (!rst) begin
      // During reset, all outputs are forced low. An in-flight op is dropped
      // without an mc_done pulse.
      state_nxt  = RUN;
      mc_cnt_nxt = 4'd0;
    end else if (mem_redirect) begin
      // The younger instructions are on the wrong path. Any multi-cycle op in
      // flight is abandoned without an mc_done pulse.
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      state_nxt   = RUN;
      mc_cnt_nxt  = 4'd0;
    end else if (state == MC_BUSY) begin
      // Hold the front end and EX. Send bubbles into MEM until the op finishes.
      // A new ex_mc_start or a load-use hazard here is ignored, because the same
      // instruction is still held in EX.
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_flush = 1'b1;
      mc_busy     = 1'b1;
      if (mc_cnt == 4'd0) begin
        mc_done   = 1'b1;
        state_nxt = RUN;
      end else begin
        mc_cnt_nxt = mc_cnt - 4'd1;
      end
    end else if (mc_start_req) begin
      // The start cycle is the first of the MC_LAT hold cycles. MC_BUSY then
      // runs mc_cnt from MC_LAT-2 down to 0, which gives MC_LAT-1 more cycles.
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_flush = 1'b1;
      state_nxt   = MC_BUSY;
      mc_cnt_nxt  = 4'(MC_LAT - 2);
    end else if (lu_hazard) begin
      // Insert one bubble. The next cycle re-checks with the load moved on to MEM.
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      mc_cnt    <= 4'd0;
      stall_cnt <= '0;
    end else begin
      state  <= state_nxt;
      mc_cnt <= mc_cnt_nxt;
      // The count saturates at all-ones instead of wrapping.
      if (pc_stall && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: self-checking bench for pipe_hazard_ctrl. It runs a table
// of single-cycle vectors, hand-written multi-cycle sequences and randomized
// traffic checked against a reference model.
// Expectations follow the PIPE_MC_UNIT_EN build setting.
module tb_pipe_hazard_ctrl;

  localparam int MC_LAT = 4;
  localparam int CNT_W  = 16;
`ifdef PIPE_MC_UNIT_EN
  localparam bit MC_EN = 1'b1;
`else
  localparam bit MC_EN = 1'b0;
`endif
  localparam longint SAT = (longint'(1) << CNT_W) - 1;

  // Output vector bit order: pc_stall, ifid_stall, ifid_flush, idex_stall,
  // idex_flush, exmem_flush, mc_busy, mc_done
  localparam logic [7:0] O_NONE  = 8'b0000_0000;
  localparam logic [7:0] O_LU    = 8'b1100_1000;
  localparam logic [7:0] O_REDIR = 8'b0010_1100;
  localparam logic [7:0] O_MCST  = 8'b1101_0100;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [4:0]       id_rs1, id_rs2, ex_wR;
  logic             id_use_rs1, id_use_rs2, ex_is_load, ex_mc_start, mem_redirect;
  logic             pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic             exmem_flush, mc_busy, mc_done;
  logic [CNT_W-1:0] stall_cnt;

  pipe_hazard_ctrl #(.MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_wR(ex_wR), .ex_is_load(ex_is_load), .ex_mc_start(ex_mc_start),
    .mem_redirect(mem_redirect),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .mc_busy(mc_busy), .mc_done(mc_done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int     errors = 0;
  int     checks = 0;
  int     m_rem  = 0;   // model: stall cycles still owed to a running MC op
  longint m_scnt = 0;   // model: stall counter

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] wr;
    logic       ld, mcs, red;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[10];

  function automatic logic [7:0] act_out();
    return {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
            exmem_flush, mc_busy, mc_done};
  endfunction

  // Reference: rules applied in priority order. An MC op owes MC_LAT stall cycles
  // in total, and mc_done marks the last one.
  function automatic logic [7:0] model_out();
    logic lu;
    lu = ex_is_load && (ex_wR != 5'd0) &&
         ((id_use_rs1 && id_rs1 == ex_wR) || (id_use_rs2 && id_rs2 == ex_wR));
    if (!rst)                    return O_NONE;
    if (mem_redirect)            return O_REDIR;
    if (m_rem > 0)               return {6'b110101, 1'b1, (m_rem == 1)};
    if (MC_EN && ex_mc_start)    return O_MCST;
    if (lu)                      return O_LU;
    return O_NONE;
  endfunction

  task automatic model_edge(input logic pcs);
    if (pcs && m_scnt < SAT) m_scnt++;
    if (mem_redirect)                    m_rem = 0;
    else if (m_rem > 0)                  m_rem--;
    else if (MC_EN && ex_mc_start)       m_rem = MC_LAT - 1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                       input logic u2, input logic [4:0] wr, input logic ld,
                       input logic mcs, input logic red);
    id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_wR = wr; ex_is_load = ld; ex_mc_start = mcs; mem_redirect = red;
  endtask

  // Check one cycle at the falling edge, then advance the model on the rising edge.
  task automatic cyc(input string name, input logic [7:0] exp);
    @(negedge clk);
    chk({name, "/out"}, 64'(act_out()), 64'(exp));
    chk({name, "/cnt"}, 64'(stall_cnt), 64'(m_scnt));
    @(posedge clk);
    model_edge(exp[7]);
    #1;
  endtask

  task automatic step(input string name);
    cyc(name, model_out());
  endtask

  initial begin
    longint s0;
    logic [7:0] e;

    //                 rs1 rs2 u1 u2 wr ld mcs red  exp
    tbl[0] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, O_NONE};
    tbl[1] = '{5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, O_LU};
    tbl[2] = '{5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 0, O_NONE};    // load to x0
    tbl[3] = '{5'd1, 5'd9, 1, 1, 5'd9, 1, 0, 0, O_LU};      // rs2 match
    tbl[4] = '{5'd7, 5'd3, 0, 1, 5'd7, 1, 0, 0, O_NONE};    // rs1 matches but unused
    tbl[5] = '{5'd4, 5'd4, 1, 1, 5'd4, 0, 0, 0, O_NONE};    // not a load
    tbl[6] = '{5'd6, 5'd0, 1, 0, 5'd6, 1, 0, 1, O_REDIR};   // redirect beats load-use
    tbl[7] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, O_REDIR};
    tbl[8] = '{5'd2, 5'd3, 1, 1, 5'd4, 1, 0, 0, O_NONE};    // no match
    tbl[9] = '{5'd31, 5'd31, 0, 1, 5'd31, 1, 0, 0, O_LU};

    // Hold reset with hazardous inputs: every output must stay 0.
    drive(5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0);
    #12;
    chk("rst_out", 64'(act_out()), 64'(O_NONE));
    chk("rst_cnt", 64'(stall_cnt), 64'd0);
    // Release with a load-use hazard present: the first edge counts it.
    drive(5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0);
    #10 rst = 1'b1;
    #1;
    chk("rel_out", 64'(act_out()), 64'(O_LU));
    @(posedge clk);
    model_edge(1'b1);
    #1;

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].wr, tbl[i].ld,
            tbl[i].mcs, tbl[i].red);
      cyc($sformatf("tbl%0d", i), tbl[i].exp);
    end

    // Load-use: one bubble, then clear. The counter goes up by one.
    s0 = m_scnt;
    drive(5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0);
    cyc("lu_a", O_LU);
    drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    cyc("lu_b", O_NONE);
    chk("lu_delta", 64'(stall_cnt), 64'(s0 + 1));

    // Multi-cycle op: MC_LAT stall cycles, mc_done on the last, then RUN.
    s0 = m_scnt;
    drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0);
    for (int k = 1; k <= 5; k++) begin
      e = O_NONE;
      if (MC_EN && k <= MC_LAT) e = {6'b110101, (k >= 2), (k == MC_LAT)};
      cyc($sformatf("mc%0d", k), e);
      drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    end
    chk("mc_delta", 64'(stall_cnt), 64'(s0 + (MC_EN ? MC_LAT : 0)));

    // A redirect in the second MC cycle aborts the op with no mc_done.
    drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0);
    cyc("ab_start", MC_EN ? O_MCST : O_NONE);
    drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
    cyc("ab_redir", O_REDIR);
    drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    cyc("ab_after1", O_NONE);
    cyc("ab_after2", O_NONE);

    // Redirect, mc start and load-use at the same time: only the flushes, stay in RUN.
    drive(5'd8, 5'd0, 1, 0, 5'd8, 1, 1, 1);
    cyc("all3", O_REDIR);
    drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    cyc("all3_after", O_NONE);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
      step("rnd");
    end

    // Asynchronous reset in the middle of an MC op.
    drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0);
    step("ar_start");
    drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("ar_out", 64'(act_out()), 64'(O_NONE));
    chk("ar_cnt", 64'(stall_cnt), 64'd0);
    m_rem  = 0;
    m_scnt = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("ar_post1");
    step("ar_post2");

    // Saturation: with a hazard held continuously, every cycle is a stall.
    drive(5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0);
    repeat (65540) @(posedge clk);
    m_scnt = (m_scnt + 65540 > SAT) ? SAT : m_scnt + 65540;
    #1;
    chk("sat", 64'(stall_cnt), 64'h0000_0000_0000_FFFF);
    step("sat_hold1");
    step("sat_hold2");
    step("sat_hold3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst.
REQ-002 Parameter MC_LAT, default 4: number of cycles EX is held for a multi-cycle operation (legal 2..16).
REQ-003 Parameter CNT_W, default 16: width of the stall statistics counter.
REQ-004 Ports SHALL be as follows:
- clk, in, 1: rising-edge clock.
- rst, in, 1: asynchronous reset, active-low.
- id_rs1, in, 5: rs1 index of the instruction in ID.
- id_rs2, in, 5: rs2 index of the instruction in ID.
- id_use_rs1, in, 1: ID instruction reads rs1.
- id_use_rs2, in, 1: ID instruction reads rs2.
- ex_wR, in, 5: destination register of the instruction in EX.
- ex_is_load, in, 1: EX instruction is a load with rf write enabled.
- ex_mc_start, in, 1: EX instruction needs the multi-cycle unit.
- mem_redirect, in, 1: the branch/jump in MEM is taken; the PC is redirected this cycle.
- pc_stall, out, 1: hold the PC.
- ifid_stall, out, 1: hold IF/ID.
- ifid_flush, out, 1: bubble IF/ID.
- idex_stall, out, 1: hold ID/EX.
- idex_flush, out, 1: bubble ID/EX.
- exmem_flush, out, 1: drives the EX/MEM flush input (clears rf_we, ram_we, npc_op, flag).
- mc_busy, out, 1: the multi-cycle unit is occupied.
- mc_done, out, 1: one-cycle pulse on the final multi-cycle cycle.
- stall_cnt, out, CNT_W: saturating count of cycles with pc_stall=1.

Function
REQ-005 The FSM SHALL have two states, RUN and MC_BUSY, plus a 4-bit down-counter mc_cnt.
REQ-006 lu_hazard SHALL be: ex_is_load && ex_wR!=0 && ((id_use_rs1 && id_rs1==ex_wR) || (id_use_rs2 && id_rs2==ex_wR)).
REQ-007 Priority SHALL be: mem_redirect > MC_BUSY > ex_mc_start > lu_hazard > normal flow.
REQ-008 On mem_redirect (any state), in the same cycle:
- ifid_flush=1, idex_flush=1, exmem_flush=1; all stalls 0.
- Next state SHALL be RUN and mc_cnt SHALL be cleared (an in-flight multi-cycle op is aborted with no mc_done).
REQ-009 RUN with ex_mc_start=1 and no redirect: outputs SHALL be pc_stall=ifid_stall=idex_stall=1 and exmem_flush=1; next state MC_BUSY; mc_cnt loads MC_LAT-2.
REQ-010 MC_BUSY with no redirect: outputs SHALL be pc_stall=ifid_stall=idex_stall=1, exmem_flush=1, mc_busy=1; mc_cnt decrements each cycle.
REQ-011 When MC_BUSY and mc_cnt==0: mc_done=1 and the stalls/exmem_flush still apply; next state RUN.
- EX SHALL therefore be held for exactly MC_LAT cycles, with the op leaving EX on the following edge.
REQ-012 RUN with lu_hazard and no higher-priority event: pc_stall=1, ifid_stall=1, idex_flush=1 for exactly one cycle (one bubble); the next cycle re-evaluates lu_hazard with the new EX contents.
REQ-013 ex_mc_start asserted while in MC_BUSY SHALL be ignored (the same instruction is held).
REQ-014 lu_hazard during MC_BUSY SHALL be ignored; ID is already stalled.
REQ-015 All control outputs SHALL be combinational from state, mc_cnt and inputs; only state, mc_cnt and stall_cnt are registered.
REQ-016 stall_cnt SHALL increment on each clk edge where pc_stall=1 and SHALL hold at all-ones (no wrap).
REQ-017 A stall and a flush of the same register SHALL never be asserted in the same cycle.

Reset
REQ-018 While rst=0: state=RUN, mc_cnt=0, stall_cnt=0, and all outputs 0.
REQ-019 Reset asserted mid multi-cycle op SHALL abort it immediately, with no mc_done.
REQ-020 The first clk edge after rst deasserts SHALL evaluate normally.

Configuration
REQ-021 With macro PIPE_MC_UNIT_EN defined, REQ-009..REQ-014 (the MC portion) and mc_busy/mc_done SHALL be implemented.
REQ-022 Without PIPE_MC_UNIT_EN:
- ex_mc_start SHALL be ignored.
- The FSM SHALL remain in RUN.
- mc_busy and mc_done SHALL be tied 0.
- Ports are unchanged.

Verification
REQ-023 Load-use: ex_is_load=1, ex_wR=5, id_rs1=5, id_use_rs1=1 for one cycle -> that cycle pc_stall=ifid_stall=idex_flush=1; next cycle all 0; stall_cnt=1.
REQ-024 x0 load: ex_is_load=1, ex_wR=0, id_rs1=0, id_use_rs1=1 -> no stall, no flush.
REQ-025 Multi-cycle, MC_LAT=4: ex_mc_start pulse -> stalls for 4 cycles, mc_done on the 4th, exmem_flush for all 4 cycles; back in RUN on the 5th; stall_cnt=4.
REQ-026 Redirect during MC_BUSY (2nd cycle) -> that cycle ifid/idex/exmem_flush=1 and stalls 0; next cycle RUN with mc_busy=0; mc_done never pulses.
REQ-027 Simultaneous mem_redirect, ex_mc_start and lu_hazard -> only the three flushes; state stays RUN.
REQ-028 rst=0 asserted asynchronously mid MC_BUSY -> all outputs 0 immediately and stall_cnt=0; with stall_cnt preloaded at saturation by repeated stalls -> value holds at 16'hFFFF.
